// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared definitions: FSM state encoding, frame length
// and the microsecond-to-cycle conversion used to size every timer.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    START,
    WAIT_FIRST,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  // Falls per host-to-device frame: 8 data, parity, stop, ack.
  localparam int unsigned FRAME_FALLS = 11;

  function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                               input int unsigned us);
    return 32'((64'(freq_hz) * 64'(us)) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer followed by a stable-sample filter.
// A level change is accepted after FILTER_LEN consecutive samples that differ
// from the current filtered level; fall_o/rise_o pulse for one cycle with it.
//   clk, reset_n : system clock, async active-low reset (level resets high)
//   line_i       : raw line level
//   level_o      : filtered level
//   fall_o/rise_o: one-cycle strobes on accepted 1->0 / 0->1 changes
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '1;
      cnt     <= '0;
      level_o <= 1'b1;
      fall_o  <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fall_o <= 1'b0;
      rise_o <= 1'b0;
      if (sync_q[1] == level_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_o <= sync_q[1];
        cnt     <= '0;
        fall_o  <= ~sync_q[1];
        rise_o  <= sync_q[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain clock/data drive).
//   clk, reset_n        : system clock, async active-low reset
//   data_i, valid_i     : command byte, taken on valid_i && ready_o
//   ready_o, busy_o     : idle / transaction in progress
//   done_o, err_o       : one-cycle completion pulse, err_o = NACK or timeout
//   ps2_clk_i/data_i    : raw line levels
//   ps2_clk_oe_o/data_oe: 1 pulls the respective line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned FREQ_HZ          = 25_000_000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned FIRST_TIMEOUT_US = 15000,
  parameter int unsigned FRAME_TIMEOUT_US = 2000,
  parameter int unsigned FILTER_LEN       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(FREQ_HZ, INHIBIT_US);
  localparam int unsigned FIRST_CYC   = us_to_cycles(FREQ_HZ, FIRST_TIMEOUT_US);
  localparam int unsigned FRAME_CYC   = us_to_cycles(FREQ_HZ, FRAME_TIMEOUT_US);
  localparam int unsigned MAX_CYC =
    (FIRST_CYC > FRAME_CYC) ? ((FIRST_CYC > INHIBIT_CYC) ? FIRST_CYC : INHIBIT_CYC)
                            : ((FRAME_CYC > INHIBIT_CYC) ? FRAME_CYC : INHIBIT_CYC);
  localparam int unsigned TW = $clog2(MAX_CYC + 1);

  logic clk_lvl, clk_fall, clk_rise_unused;
  logic data_lvl, data_fall_unused, data_rise_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .line_i  (ps2_clk_i),
    .level_o (clk_lvl),
    .fall_o  (clk_fall),
    .rise_o  (clk_rise_unused)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .line_i  (ps2_data_i),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused),
    .rise_o  (data_rise_unused)
  );

  ps2_state_t    state;
  logic [TW-1:0] timer;
  logic [7:0]    sh;
  logic          par;
  logic [3:0]    bit_cnt;
  logic          nack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer         <= '0;
      sh            <= '0;
      par           <= 1'b0;
      bit_cnt       <= '0;
      nack          <= 1'b0;
      ready_o       <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      ps2_clk_oe_o  <= 1'b0;
      ps2_data_oe_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (state inside {WAIT_FIRST, DATA, PARITY, STOP, ACK, WAIT_IDLE} && timer == '0) begin
        // Device never answered or stalled mid-frame: abandon the frame.
        ps2_clk_oe_o  <= 1'b0;
        ps2_data_oe_o <= 1'b0;
        done_o        <= 1'b1;
        err_o         <= 1'b1;
        state         <= IDLE;
      end else begin
        if (timer != '0) timer <= timer - TW'(1);
        case (state)
          IDLE: begin
            if (valid_i && ready_o) begin
              sh           <= data_i;
              par          <= ~^data_i;
              bit_cnt      <= '0;
              timer        <= TW'(INHIBIT_CYC - 1);
              ps2_clk_oe_o <= 1'b1;
              ready_o      <= 1'b0;
              busy_o       <= 1'b1;
              state        <= INHIBIT;
            end else begin
              ready_o <= 1'b1;
              busy_o  <= 1'b0;
            end
          end
          INHIBIT: begin
            if (timer == '0) begin
              ps2_data_oe_o <= 1'b1;
              state         <= START;
            end
          end
          START: begin
            ps2_clk_oe_o <= 1'b0;
            timer        <= TW'(FIRST_CYC - 1);
            state        <= WAIT_FIRST;
          end
          WAIT_FIRST: begin
            if (clk_fall) begin
              ps2_data_oe_o <= ~sh[0];
              sh            <= {1'b0, sh[7:1]};
              bit_cnt       <= 4'd1;
              timer         <= TW'(FRAME_CYC - 1);
              state         <= DATA;
            end
          end
          DATA: begin
            if (clk_fall) begin
              if (bit_cnt == 4'd8) begin
                ps2_data_oe_o <= ~par;
                state         <= PARITY;
              end else begin
                ps2_data_oe_o <= ~sh[0];
                sh            <= {1'b0, sh[7:1]};
              end
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          PARITY: begin
            if (clk_fall) begin
              ps2_data_oe_o <= 1'b0;
              bit_cnt       <= bit_cnt + 4'd1;
              state         <= STOP;
            end
          end
          STOP: begin
            if (clk_fall) begin
              bit_cnt <= 4'(FRAME_FALLS);
              state   <= ACK;
            end
          end
          ACK: begin
            // Device holds data through the low half of the ack clock.
            nack  <= data_lvl;
            state <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            if (clk_lvl && data_lvl) begin
              done_o <= 1'b1;
              err_o  <= nack;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
